// File: rtl/bitop_arbiter.sv
// Round-robin arbiter sharing one registered W-bit bit-manipulation unit between two requesters.
// Optional grant statistics counters are built when BITOP_ARB_STATS_EN is defined.
module bitop_arbiter #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data
`ifdef BITOP_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_cnt0,
    output logic [CNT_W-1:0] stat_cnt1
`endif
);

    localparam int SH_W = (W > 2) ? $clog2(W) : 1;

    typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } state_e;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_REV  = 3'd1,
        OP_SHR  = 3'd2,
        OP_SWAP = 3'd3,
        OP_XOR  = 3'd4,
        OP_AND  = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } op_e;

    state_e         state_q, state_d;
    logic           prio_q, prio_d;
    logic           id_q, id_d;
    logic [W-1:0]   data_q, data_d;

    logic           can_accept;
    logic           winner;
    logic           transfer;
    logic [2:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

`ifdef BITOP_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
`endif

    function automatic logic [W-1:0] bitop(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op_e'(op))
            OP_PASS: r = a;
            OP_REV:  for (int i = 0; i < W; i++) r[i] = a[W-1-i];
            OP_SHR:  r = a >> b[SH_W-1:0];
            OP_SWAP: r = {a[W/2-1:0], a[W-1:W/2]};
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Winner depends only on valids and prio; ready is gated by result-register space.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready;
        if (req0_valid && req1_valid)
            winner = prio_q;
        else
            winner = req1_valid;

        req0_ready = !rst && can_accept && req0_valid && !winner;
        req1_ready = !rst && can_accept && req1_valid && winner;
        transfer   = req0_ready || req1_ready;

        sel_op = winner ? req1_op : req0_op;
        sel_a  = winner ? req1_a  : req0_a;
        sel_b  = winner ? req1_b  : req0_b;
    end

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        data_d  = data_q;
        if (transfer) begin
            state_d = FULL;
            data_d  = bitop(sel_op, sel_a, sel_b);
            id_d    = winner;
            prio_d  = !winner;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef BITOP_ARB_STATS_EN
    // Counters saturate rather than wrap so a long run never reports a small count.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && cnt0_q != {CNT_W{1'b1}})
            cnt0_d = cnt0_q + CNT_W'(1);
        if (req1_ready && cnt1_q != {CNT_W{1'b1}})
            cnt1_d = cnt1_q + CNT_W'(1);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
`ifdef BITOP_ARB_STATS_EN
            cnt0_q  <= '0;
            cnt1_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            data_q  <= data_d;
`ifdef BITOP_ARB_STATS_EN
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
`endif
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

`ifdef BITOP_ARB_STATS_EN
    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// Self-checking bench for bitop_arbiter: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_bitop_arbiter;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int MASK  = (1 << W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [2:0]     req0_op = '0, req1_op = '0;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;
`ifdef BITOP_ARB_STATS_EN
    logic [CNT_W-1:0] stat_cnt0, stat_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bitop_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef BITOP_ARB_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed from the operation definitions with integer arithmetic.
    function automatic int ref_op(input int op, input int a, input int b);
        int r;
        r = 0;
        case (op)
            0: r = a;
            1: for (int i = 0; i < W; i++) r = r | (((a >> i) & 1) << (W - 1 - i));
            2: r = a >> (b % W);
            3: r = ((a << (W / 2)) | (a >> (W / 2))) & MASK;
            4: r = a ^ b;
            5: r = a & b;
            6: r = (a + b) & MASK;
            default: r = (a - b) & MASK;
        endcase
        return r;
    endfunction

    // Model state: result register contents, fairness pointer, grant counts.
    bit m_full, m_id, m_prio, m_acc0, m_acc1, chk_en;
    int m_data, m_cnt0, m_cnt1;

    function automatic void model_ready(output bit r0, output bit r1);
        bit can;
        bit win;
        can = !rst && (!m_full || rsp_ready);
        win = (req0_valid && req1_valid) ? m_prio : req1_valid;
        r0  = can && req0_valid && !win;
        r1  = can && req1_valid && win;
    endfunction

    always @(posedge clk) begin
        bit r0, r1;
        model_ready(r0, r1);
        m_acc0 = r0;
        m_acc1 = r1;
        chk_en = 1'b1;
        if (rst) begin
            m_full = 0; m_id = 0; m_prio = 0; m_data = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (r0 || r1) begin
            m_full = 1;
            m_id   = r1;
            m_prio = !r1;
            m_data = r1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
            if (r0 && m_cnt0 < CMAX) m_cnt0++;
            if (r1 && m_cnt1 < CMAX) m_cnt1++;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    end

    // Compare process: outputs are stable around the falling edge.
    always @(negedge clk) begin
        bit r0, r1;
        if (chk_en) begin
            model_ready(r0, r1);
            check("m_req0_ready", req0_ready, r0);
            check("m_req1_ready", req1_ready, r1);
            check("m_rsp_valid", rsp_valid, m_full);
            if (m_full) begin
                check("m_rsp_data", rsp_data, m_data);
                check("m_rsp_id", rsp_id, m_id);
            end
`ifdef BITOP_ARB_STATS_EN
            check("m_stat_cnt0", stat_cnt0, m_cnt0);
            check("m_stat_cnt1", stat_cnt1, m_cnt1);
`endif
        end
    end

    task automatic set_req0(input bit v, input int op, input int a, input int b);
        req0_valid = v; req0_op = 3'(op); req0_a = W'(a); req0_b = W'(b);
    endtask

    task automatic set_req1(input bit v, input int op, input int a, input int b);
        req1_valid = v; req1_op = 3'(op); req1_a = W'(a); req1_b = W'(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; set_req0(0, 0, 0, 0); set_req1(0, 0, 0, 0); rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int op_tab[7]  = '{2, 3, 4, 5, 6, 7, 7};
    int a_tab[7]   = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00};
    int b_tab[7]   = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h01};
    int exp_tab[7] = '{8'h1E, 8'h0F, 8'hF3, 8'h00, 8'hF3, 8'hED, 8'hFF};

    initial begin
        // Reset values
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        check("rst_ready0", req0_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reverse of a single low bit
        @(posedge clk); #1;
        set_req0(1, 1, 8'h01, 0);
        @(negedge clk);
        check("t1_ready0", req0_ready, 1);
        @(posedge clk); #1;
        set_req0(0, 0, 0, 0);
        @(negedge clk);
        check("t1_valid", rsp_valid, 1);
        check("t1_data", rsp_data, 8'h80);
        check("t1_id", rsp_id, 0);

        // Both requesters continuously valid: grants alternate, no bubbles
        do_reset();
        set_req0(1, 0, 8'h11, 0);
        set_req1(1, 0, 8'h22, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("t2_grant1", req1_ready, i % 2);
            if (i > 0) begin
                check("t2_valid", rsp_valid, 1);
                check("t2_data", rsp_data, (i % 2 == 1) ? 8'h11 : 8'h22);
            end
        end
        @(posedge clk); #1;
        set_req0(0, 0, 0, 0); set_req1(0, 0, 0, 0);
        @(negedge clk);
        check("t2_last", rsp_data, 8'h22);

        // Backpressure holds the result and blocks both requesters
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_idle", rsp_valid, 0);
        @(posedge clk); #1;
        set_req0(1, 0, 8'h44, 0); rsp_ready = 1'b0;
        @(negedge clk);
        check("t3_accept", req0_ready, 1);
        @(posedge clk); #1;
        set_req0(1, 0, 8'h55, 0); set_req1(1, 0, 8'h66, 0);
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_r0", req0_ready, 0);
            check("t3_hold_r1", req1_ready, 0);
            check("t3_hold_data", rsp_data, 8'h44);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_drain_r1", req1_ready, 1);
        @(posedge clk); #1;
        set_req1(0, 0, 0, 0);
        @(negedge clk);
        check("t3_next_valid", rsp_valid, 1);
        check("t3_next_data", rsp_data, 8'h66);
        check("t3_next_id", rsp_id, 1);
        @(posedge clk); #1;
        set_req0(0, 0, 0, 0);
        @(negedge clk);
        check("t3_r0_data", rsp_data, 8'h55);

        // Operation coverage
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            set_req0(1, op_tab[i], a_tab[i], b_tab[i]);
            @(posedge clk); #1;
            set_req0(0, 0, 0, 0);
            @(negedge clk);
            check($sformatf("t4_op%0d", op_tab[i]), rsp_data, exp_tab[i]);
        end

        // Reset while FULL with both requesters pending
        @(posedge clk); #1;
        rsp_ready = 1'b0; set_req0(1, 0, 8'h77, 0);
        @(posedge clk); #1;
        set_req0(1, 0, 8'h78, 0); set_req1(1, 0, 8'h79, 0); rst = 1'b1;
        @(negedge clk);
        check("t5_rst_r0", req0_ready, 0);
        check("t5_rst_r1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_valid", rsp_valid, 0);
        check("t5_grant0", req0_ready, 1);
        check("t5_grant1", req1_ready, 0);
        @(posedge clk); #1;
        set_req0(0, 0, 0, 0);
        @(negedge clk);
        check("t5_data", rsp_data, 8'h78);
        check("t5_id", rsp_id, 0);
        @(posedge clk); #1;
        set_req1(0, 0, 0, 0);

`ifdef BITOP_ARB_STATS_EN
        // Saturating grant counter
        do_reset();
        set_req0(1, 0, 8'h01, 0);
        @(negedge clk);
        check("t6_cnt0_init", stat_cnt0, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t6_cnt0", stat_cnt0, (k < 3) ? k : 3);
            check("t6_cnt1", stat_cnt1, 0);
        end
        @(posedge clk); #1;
        set_req0(0, 0, 0, 0);
`endif

        // Randomized traffic; a requester holds its operation until accepted
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid || m_acc0)
                set_req0($urandom_range(0, 2) != 0, $urandom_range(0, 7),
                         $urandom_range(0, MASK), $urandom_range(0, MASK));
            if (!req1_valid || m_acc1)
                set_req1($urandom_range(0, 2) != 0, $urandom_range(0, 7),
                         $urandom_range(0, MASK), $urandom_range(0, MASK));
        end
        @(posedge clk); #1;
        rst = 1'b0; set_req0(0, 0, 0, 0); set_req1(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
